// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit counters, ID-stage verify and train.
// Define BTB_STATS_EN to add saturating lookupCnt/mispredCnt outputs.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pcF,
    input  logic            stallD,
    input  logic            flushD,
    output logic            predTakenF,
    output logic [PC_W-1:0] predTargetF,
    input  logic            isBranchD,
    input  logic            resTakenD,
    input  logic [PC_W-1:0] resTargetD,
    output logic            mispredictD,
    output logic [PC_W-1:0] redirectPCD
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     lookupCnt,
    output logic [31:0]     mispredCnt
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0]  tgt_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic             id_valid;
    logic [PC_W-1:0]  id_pc;
    logic             id_taken;
    logic [PC_W-1:0]  id_target;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    logic             f_hit;
    logic             d_hit;
    logic             eval;
    logic             br_mis;
    logic [1:0]       d_ctr;
    logic             unused_bits;
    assign unused_bits = &{1'b0, pcF[1:0], id_pc[1:0]};
    always_comb begin
        f_idx       = pcF[IDX_W+1:2];
        d_idx       = id_pc[IDX_W+1:2];
        f_hit       = valid_q[f_idx] && tag_q[f_idx] == pcF[PC_W-1:IDX_W+2];
        d_hit       = valid_q[d_idx] && tag_q[d_idx] == id_pc[PC_W-1:IDX_W+2];
        d_ctr       = ctr_q[d_idx];
        predTakenF  = f_hit && ctr_q[f_idx][1];
        predTargetF = f_hit ? tgt_q[f_idx] : pcF + PC_W'(4);
        eval        = id_valid && !stallD;
        br_mis      = id_taken != resTakenD || (id_taken && resTakenD && id_target != resTargetD);
        // a predicted-taken non-branch is an alias and always redirects to the fall-through
        mispredictD = eval && (isBranchD ? br_mis : id_taken);
        redirectPCD = isBranchD && resTakenD ? resTargetD : id_pc + PC_W'(4);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
            id_valid  <= 1'b0;
            id_pc     <= '0;
            id_taken  <= 1'b0;
            id_target <= '0;
        end else begin
            if (!stallD) begin
                id_valid  <= !flushD;
                id_pc     <= pcF;
                id_taken  <= predTakenF;
                id_target <= predTargetF;
            end
            if (eval && isBranchD) begin
                if (d_hit) begin
                    ctr_q[d_idx] <= resTakenD ? (d_ctr == 2'b11 ? 2'b11 : d_ctr + 2'd1)
                                              : (d_ctr == 2'b00 ? 2'b00 : d_ctr - 2'd1);
                    if (resTakenD) tgt_q[d_idx] <= resTargetD;
                end else begin
                    valid_q[d_idx] <= 1'b1;
                    tag_q[d_idx]   <= id_pc[PC_W-1:IDX_W+2];
                    tgt_q[d_idx]   <= resTargetD;
                    ctr_q[d_idx]   <= resTakenD ? 2'b10 : 2'b01;
                end
            end else if (eval && id_taken) begin
                valid_q[d_idx] <= 1'b0;
            end
        end
    end
`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lookupCnt  <= '0;
            mispredCnt <= '0;
        end else begin
            if (!stallD && !flushD && lookupCnt != '1) lookupCnt <= lookupCnt + 32'd1;
            if (mispredictD && mispredCnt != '1) mispredCnt <= mispredCnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed vectors with a queue-based scoreboard and negedge monitor.
module tb_branch_target_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD;
    logic        flushD;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        isBranchD;
    logic        resTakenD;
    logic [31:0] resTargetD;
    logic        mispredictD;
    logic [31:0] redirectPCD;
`ifdef BTB_STATS_EN
    logic [31:0] lookupCnt;
    logic [31:0] mispredCnt;
`endif
    int checks = 0;
    int errors = 0;
    typedef struct {
        string       name;
        logic        cf;
        logic        tk;
        logic [31:0] tg;
        logic        cd;
        logic        mis;
        logic [31:0] red;
    } exp_t;
    exp_t q[$];
    branch_target_predictor #(.ENTRIES(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
        .predTakenF(predTakenF), .predTargetF(predTargetF),
        .isBranchD(isBranchD), .resTakenD(resTakenD), .resTargetD(resTargetD),
        .mispredictD(mispredictD), .redirectPCD(redirectPCD)
`ifdef BTB_STATS_EN
        , .lookupCnt(lookupCnt), .mispredCnt(mispredCnt)
`endif
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.cf) begin
                checks++;
                if (predTakenF !== e.tk) begin
                    errors++;
                    $display("FAIL %s predTakenF got %0d exp %0d", e.name, predTakenF, e.tk);
                end
                checks++;
                if (predTargetF !== e.tg) begin
                    errors++;
                    $display("FAIL %s predTargetF got %h exp %h", e.name, predTargetF, e.tg);
                end
            end
            if (e.cd) begin
                checks++;
                if (mispredictD !== e.mis) begin
                    errors++;
                    $display("FAIL %s mispredictD got %0d exp %0d", e.name, mispredictD, e.mis);
                end
                if (e.mis) begin
                    checks++;
                    if (redirectPCD !== e.red) begin
                        errors++;
                        $display("FAIL %s redirectPCD got %h exp %h", e.name, redirectPCD, e.red);
                    end
                end
            end
        end
    end
    // one cycle: F-side pc plus ID-side resolution, with expected outputs for that cycle
    task automatic v(input string n, input logic r, input logic st, input logic fl,
                     input logic [31:0] pc, input logic ib, input logic rt, input logic [31:0] rg,
                     input logic cf, input logic etk, input logic [31:0] etg,
                     input logic cd, input logic emis, input logic [31:0] ered);
        exp_t e;
        rst = r; stallD = st; flushD = fl; pcF = pc;
        isBranchD = ib; resTakenD = rt; resTargetD = rg;
        e.name = n; e.cf = cf; e.tk = etk; e.tg = etg; e.cd = cd; e.mis = emis; e.red = ered;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1; stallD = 1'b0; flushD = 1'b0; pcF = 32'h40;
        isBranchD = 1'b0; resTakenD = 1'b0; resTargetD = 32'h0;
        @(posedge clk);
        #1;
        //  name        rst st fl pc            ib rt rg            cf tk tg            cd mis red
        v("rst0",       1, 0, 0, 32'h40,       0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0);
        v("rst1",       1, 0, 0, 32'h40,       0, 0, 32'h0,        1, 0, 32'h44,       1, 0, 32'h0);
        v("post_rst",   0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 0, 32'h44,       1, 0, 32'h0);
        v("nonbr",      0, 0, 0, 32'h44,       0, 0, 32'h0,        1, 0, 32'h48,       1, 0, 32'h0);
        v("nonbr2",     0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 0, 32'h44,       1, 0, 32'h0);
        v("first_tk",   0, 0, 1, 32'h80,       1, 1, 32'h80,       1, 0, 32'h84,       1, 1, 32'h80);
        v("pred_tk",    0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'h80,       1, 0, 32'h0);
        v("ntk_mis",    0, 0, 1, 32'h80,       1, 0, 32'h80,       1, 0, 32'h84,       1, 1, 32'h44);
        v("ctr01_ntk",  0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 0, 32'h80,       1, 0, 32'h0);
        v("tk_1",       0, 0, 1, 32'h44,       1, 1, 32'h80,       1, 0, 32'h48,       1, 1, 32'h80);
        v("ctr10",      0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'h80,       1, 0, 32'h0);
        v("tk_2",       0, 0, 0, 32'h80,       1, 1, 32'h80,       1, 0, 32'h84,       1, 0, 32'h0);
        v("ctr11",      0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'h80,       1, 0, 32'h0);
        v("tk_3_sat",   0, 0, 0, 32'h80,       1, 1, 32'h80,       1, 0, 32'h84,       1, 0, 32'h0);
        v("ctr11b",     0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'h80,       1, 0, 32'h0);
        v("sat_ntk",    0, 0, 1, 32'h80,       1, 0, 32'h80,       1, 0, 32'h84,       1, 1, 32'h44);
        v("still_tk",   0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'h80,       1, 0, 32'h0);
        v("tgt_mis",    0, 0, 1, 32'h80,       1, 1, 32'hC0,       1, 0, 32'h84,       1, 1, 32'hC0);
        v("new_tgt",    0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'hC0,       1, 0, 32'h0);
        v("stall1",     0, 1, 0, 32'h44,       1, 0, 32'h0,        1, 0, 32'h48,       1, 0, 32'h0);
        v("stall2",     0, 1, 0, 32'h44,       1, 0, 32'h0,        1, 0, 32'h48,       1, 0, 32'h0);
        v("release",    0, 0, 1, 32'h44,       1, 0, 32'h0,        1, 0, 32'h48,       1, 1, 32'h44);
        v("once_only",  0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 1, 32'hC0,       1, 0, 32'h0);
        v("same_cyc",   0, 0, 1, 32'h40,       1, 0, 32'h0,        1, 1, 32'hC0,       1, 1, 32'h44);
        v("flushed",    0, 0, 0, 32'h40,       1, 1, 32'hC0,       1, 0, 32'hC0,       1, 0, 32'h0);
        v("pre_alias",  0, 0, 0, 32'h80,       0, 0, 32'h0,        1, 0, 32'h84,       1, 0, 32'h0);
        v("alloc_80",   0, 0, 1, 32'h84,       1, 1, 32'h100,      1, 0, 32'h88,       1, 1, 32'h100);
        v("hit_80",     0, 0, 0, 32'h80,       0, 0, 32'h0,        1, 1, 32'h100,      1, 0, 32'h0);
        v("alias",      0, 0, 1, 32'h100,      0, 0, 32'h0,        1, 0, 32'h104,      1, 1, 32'h84);
        v("alias_gone", 0, 0, 0, 32'h80,       0, 0, 32'h0,        1, 0, 32'h84,       1, 0, 32'h0);
        v("wrap_f",     0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0);
        v("alloc_top",  0, 0, 1, 32'h0,        1, 1, 32'h10,       1, 0, 32'h4,        1, 1, 32'h10);
        v("hit_top",    0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 1, 32'h10,       1, 0, 32'h0);
        v("wrap_d",     0, 0, 1, 32'h10,       1, 0, 32'h0,        1, 0, 32'h14,       1, 1, 32'h0);
        v("top_01",     0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 0, 32'h10,       1, 0, 32'h0);
        v("top_tk",     0, 0, 0, 32'h10,       1, 1, 32'h10,       1, 0, 32'h14,       1, 1, 32'h10);
        v("rst_mid",    1, 0, 0, 32'hFFFFFFFC, 0, 0, 32'h0,        1, 1, 32'h10,       1, 0, 32'h0);
        v("after_rst",  0, 0, 0, 32'hFFFFFFFC, 1, 1, 32'h10,       1, 0, 32'h0,        1, 0, 32'h0);
        v("after_rst2", 0, 0, 0, 32'h40,       0, 0, 32'h0,        1, 0, 32'h44,       1, 0, 32'h0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
